// File: rtl/systolic_array_stream_ctrl_pkg.sv
// Shared constants and state type for the systolic tile stream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;
  localparam int N            = 3;
  localparam int DW           = 8;
  localparam int ACC_W        = 16;
  localparam int K_W          = 8;
  localparam int DRAIN_CYCLES = 2*N-1;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES+1);
  localparam int IN_W         = 2*N*DW;
  localparam int OUT_W        = N*N*ACC_W;
  localparam int PERF_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUT     = 3'd5
  } sa_ctrl_state_t;
endpackage

// File: rtl/systolic_array_stream_ctrl_perf.sv
// Saturating tile/stall counters for the tile controller (present only with SA_CTRL_PERF_EN).
// Latency: counters update one cycle after the qualifying event.
// Backpressure: none; pure observers.
`ifdef SA_CTRL_PERF_EN
module sa_perf_counters
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tile_inc,
  input  logic              i_stall_inc,
  output logic [PERF_W-1:0] perf_tiles,
  output logic [PERF_W-1:0] perf_stalls
);
  logic [PERF_W-1:0] r_tiles;
  logic [PERF_W-1:0] r_stalls;

  // Count events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tiles  <= '0;
      r_stalls <= '0;
    end else begin
      if (i_tile_inc && (r_tiles != '1))
        r_tiles <= r_tiles + PERF_W'(1);
      if (i_stall_inc && (r_stalls != '1))
        r_stalls <= r_stalls + PERF_W'(1);
    end
  end

  assign perf_tiles  = r_tiles;
  assign perf_stalls = r_stalls;
endmodule
`endif

// File: rtl/systolic_array_stream_ctrl.sv
// Sequences one NxN systolic tile: clear, K operand beats, drain, capture, emit one result beat.
// Latency: result valid K+8 cycles after the IDLE cycle that samples s_axis_valid (N=3).
// Backpressure: s_axis_ready only in LOAD; result held in OUT until m_axis_ready. Optional SA_CTRL_PERF_EN adds perf counters.
module systolic_array_stream_ctrl
  import systolic_pkg::*;
(
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic [K_W-1:0]    cfg_k_len,
  input  logic              s_axis_valid,
  input  logic [IN_W-1:0]   s_axis_data,
  output logic              s_axis_ready,
  output logic              arr_clear,
  output logic              arr_en,
  output logic [N*DW-1:0]   arr_a,
  output logic [N*DW-1:0]   arr_b,
  input  logic [OUT_W-1:0]  arr_result,
  output logic              m_axis_valid,
  output logic [OUT_W-1:0]  m_axis_data,
  input  logic              m_axis_ready,
  output logic              busy
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_tiles,
  output logic [PERF_W-1:0] perf_stalls
`endif
);
  sa_ctrl_state_t     r_state;
  sa_ctrl_state_t     w_next;
  logic [K_W-1:0]     r_k_len;
  logic [K_W-1:0]     r_beat_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic               r_m_valid;
  logic [OUT_W-1:0]   r_m_data;
  logic               w_last_beat;
  logic               w_drain_done;

  assign w_last_beat  = (r_beat_cnt == (r_k_len - K_W'(1)));
  assign w_drain_done = (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES-1));

  // State register.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and array/stream strobes; operands are forwarded only on a real handshake.
  always_comb begin
    w_next       = r_state;
    s_axis_ready = 1'b0;
    arr_clear    = 1'b0;
    arr_en       = 1'b0;
    arr_a        = '0;
    arr_b        = '0;
    case (r_state)
      ST_IDLE: begin
        if (s_axis_valid && (cfg_k_len != '0)) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        arr_clear = 1'b1;
        w_next    = ST_LOAD;
      end
      ST_LOAD: begin
        s_axis_ready = 1'b1;
        if (s_axis_valid) begin
          arr_en = 1'b1;
          arr_a  = s_axis_data[N*DW-1:0];
          arr_b  = s_axis_data[IN_W-1:N*DW];
          if (w_last_beat) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        arr_en = 1'b1;
        if (w_drain_done) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Tile length latch plus beat and drain counters; both restart from zero every tile.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt  <= '0;
          r_drain_cnt <= '0;
          if (w_next == ST_CLEAR) r_k_len <= cfg_k_len;
        end
        ST_LOAD: begin
          if (s_axis_valid)
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + K_W'(1);
        end
        ST_DRAIN: begin
          r_drain_cnt <= w_drain_done ? '0 : r_drain_cnt + DRAIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register: snapshot accumulators once, hold until the consumer takes the beat.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_m_valid <= 1'b1;
      r_m_data  <= arr_result;
    end else if ((r_state == ST_OUT) && m_axis_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_axis_valid = r_m_valid;
  assign m_axis_data  = r_m_data;
  assign busy         = (r_state != ST_IDLE);

`ifdef SA_CTRL_PERF_EN
  logic w_tile_inc;
  logic w_stall_inc;
  assign w_tile_inc  = (r_state == ST_OUT) && m_axis_ready;
  assign w_stall_inc = ((r_state == ST_LOAD) && !s_axis_valid) ||
                       ((r_state == ST_OUT)  && !m_axis_ready);

  sa_perf_counters u_perf (
    .clk         (axi_clk),
    .rst         (axi_rst),
    .i_tile_inc  (w_tile_inc),
    .i_stall_inc (w_stall_inc),
    .perf_tiles  (perf_tiles),
    .perf_stalls (perf_stalls)
  );
`endif
endmodule

// File: tb/tb_systolic_array_stream_ctrl.sv
// Bench for systolic_array_stream_ctrl with a behavioural skewed 3x3 array in the loop.
// Expected tiles come from a plain outer-product sum and are checked by a scoreboard.
module tb_systolic_array_stream_ctrl;
  logic         axi_clk = 1'b0;
  logic         axi_rst = 1'b1;
  logic [7:0]   cfg_k_len = '0;
  logic         s_axis_valid = 1'b0;
  logic [47:0]  s_axis_data = '0;
  logic         s_axis_ready;
  logic         arr_clear, arr_en;
  logic [23:0]  arr_a, arr_b;
  logic [143:0] arr_result;
  logic         m_axis_valid;
  logic [143:0] m_axis_data;
  logic         m_axis_ready = 1'b1;
  logic         busy;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]  perf_tiles, perf_stalls;
`endif

  systolic_array_stream_ctrl dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .cfg_k_len(cfg_k_len),
    .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
    .arr_clear(arr_clear), .arr_en(arr_en), .arr_a(arr_a), .arr_b(arr_b),
    .arr_result(arr_result), .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data),
    .m_axis_ready(m_axis_ready), .busy(busy)
`ifdef SA_CTRL_PERF_EN
    , .perf_tiles(perf_tiles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  // Skewed output-stationary array: PE(i,j) sees operands i+j+1 advances after they enter,
  // so the last beat reaches PE(2,2) only after 2N-1 drain advances.
  logic [7:0]  ha [5][3];
  logic [7:0]  hb [5][3];
  logic [15:0] acc [3][3];
  always @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst || arr_clear) begin
      for (int d = 0; d < 5; d++) for (int l = 0; l < 3; l++) begin ha[d][l] <= '0; hb[d][l] <= '0; end
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) acc[i][j] <= '0;
    end else if (arr_en) begin
      for (int l = 0; l < 3; l++) begin ha[0][l] <= arr_a[l*8 +: 8]; hb[0][l] <= arr_b[l*8 +: 8]; end
      for (int d = 1; d < 5; d++) for (int l = 0; l < 3; l++) begin ha[d][l] <= ha[d-1][l]; hb[d][l] <= hb[d-1][l]; end
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
        acc[i][j] <= acc[i][j] + 16'(ha[i+j][i]) * 16'(hb[i+j][j]);
    end
  end
  always_comb begin
    arr_result = '0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) arr_result[(i*3+j)*16 +: 16] = acc[i][j];
  end

  typedef struct {
    int           k;
    logic [47:0]  beat [4];
    bit           gap;
    logic [143:0] exp;
  } vec_t;

  int errors = 0, checks = 0, cyc_cnt = 0;
  logic [143:0] exp_mem [32];
  int wr_idx = 0, rd_idx = 0;
  int clr_cnt = 0, last_clr = -1, first_en = -1, load_en = 0, rise_cyc = -1;
  logic prev_busy = 1'b0, prev_mv = 1'b0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] calc(input int k, input logic [47:0] b0, b1, b2, b3);
    logic [47:0]  bt [4];
    logic [143:0] r;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    r = '0;
    for (int b = 0; b < k; b++)
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
        r[(i*3+j)*16 +: 16] = r[(i*3+j)*16 +: 16] + 16'(bt[b][i*8 +: 8]) * 16'(bt[b][24+j*8 +: 8]);
    return r;
  endfunction

  // Drives one tile and pushes its expected result; returns the cycle count seen in the sampling IDLE cycle.
  task automatic send_tile(input int k, input logic [47:0] b0, b1, b2, b3, input bit gap,
                           input logic [143:0] exp, output int t0);
    logic [47:0] bt [4];
    int idx = 0, cyc = 0;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    t0 = -1;
    exp_mem[wr_idx % 32] = exp; wr_idx++;
    @(posedge axi_clk); #1;
    cfg_k_len = 8'(k); s_axis_valid = 1'b1; s_axis_data = bt[0];
    while (idx < k && cyc < 300) begin
      @(negedge axi_clk);
      if (!busy && t0 < 0) t0 = cyc_cnt;
      if (s_axis_valid && s_axis_ready) idx++;
      @(posedge axi_clk); #1;
      cyc++;
      if (busy) cfg_k_len = 8'hC8;  // must be ignored once the tile has started
      if (idx >= k) s_axis_valid = 1'b0;
      else s_axis_valid = gap ? ~s_axis_valid : 1'b1;
      s_axis_data = s_axis_valid ? bt[idx % 4] : 48'hDEAD_BEEF_CAFE;
    end
    chk("send_beats", 144'(idx), 144'(k));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(rd_idx == wr_idx && !busy && !m_axis_valid) && n < 200) begin
      @(negedge axi_clk); n++;
    end
    chk("done_timeout", 144'(n >= 200), 144'(0));
  endtask

  vec_t tbl [4];
  logic [143:0] ref_gap;

  initial begin
    int t0, n, outs_before;
    fork
      forever begin
        @(posedge axi_clk); cyc_cnt++;
      end
      forever begin
        @(negedge axi_clk);
        chk("clear_en_excl", 144'(arr_clear && arr_en), 144'(0));
        if (busy && !prev_busy) begin clr_cnt = 0; first_en = -1; load_en = 0; end
        if (arr_clear) begin clr_cnt++; last_clr = cyc_cnt; end
        if (arr_en && first_en < 0) first_en = cyc_cnt;
        if (arr_en && s_axis_ready) load_en++;
        if (m_axis_valid && !prev_mv) rise_cyc = cyc_cnt;
        if (m_axis_valid && m_axis_ready) begin
          if (rd_idx == wr_idx) chk("unexpected_out", 144'(1), 144'(0));
          else begin chk("out_data", m_axis_data, exp_mem[rd_idx % 32]); rd_idx++; end
        end
        prev_busy = busy; prev_mv = m_axis_valid;
      end
    join_none

    // Reset state.
    @(negedge axi_clk);
    chk("rst_s_ready", 144'(s_axis_ready), 0);
    chk("rst_strobes", 144'({arr_clear, arr_en}), 0);
    chk("rst_operands", 144'({arr_a, arr_b}), 0);
    chk("rst_m_valid", 144'(m_axis_valid), 0);
    chk("rst_m_data", m_axis_data, 0);
    chk("rst_busy", 144'(busy), 0);
    @(posedge axi_clk); #1 axi_rst = 1'b0;

    // Zero-length config never starts a tile nor consumes the beat.
    cfg_k_len = 8'd0; s_axis_valid = 1'b1; s_axis_data = 48'h010101010101;
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_clk);
      chk("k0_s_ready", 144'(s_axis_ready), 0);
      chk("k0_busy", 144'(busy), 0);
    end
`ifdef SA_CTRL_PERF_EN
    chk("k0_perf_tiles", 144'(perf_tiles), 0);
`endif
    @(posedge axi_clk); #1 s_axis_valid = 1'b0;

    // Vector table.
    tbl[0].k = 2; tbl[0].gap = 0;
    tbl[0].beat[0] = 48'h010101010101; tbl[0].beat[1] = 48'h010101010101;
    tbl[0].beat[2] = '0; tbl[0].beat[3] = '0;
    tbl[0].exp = {9{16'h0002}};
    tbl[1].k = 1; tbl[1].gap = 0;
    tbl[1].beat[0] = 48'h060504030201; tbl[1].beat[1] = '0; tbl[1].beat[2] = '0; tbl[1].beat[3] = '0;
    tbl[1].exp = {16'd18, 16'd15, 16'd12, 16'd12, 16'd10, 16'd8, 16'd6, 16'd5, 16'd4};
    tbl[2].k = 4; tbl[2].gap = 1;
    tbl[2].beat[0] = 48'h0A0B0C010203; tbl[2].beat[1] = 48'h111213040506;
    tbl[2].beat[2] = 48'h20FF01FF0710; tbl[2].beat[3] = 48'h030201808182;
    ref_gap = calc(4, tbl[2].beat[0], tbl[2].beat[1], tbl[2].beat[2], tbl[2].beat[3]);
    tbl[2].exp = ref_gap;
    tbl[3] = tbl[2]; tbl[3].gap = 0;

    for (int v = 0; v < 4; v++) begin
      send_tile(tbl[v].k, tbl[v].beat[0], tbl[v].beat[1], tbl[v].beat[2], tbl[v].beat[3],
                tbl[v].gap, tbl[v].exp, t0);
      wait_done();
      chk("clear_len", 144'(clr_cnt), 144'(1));
      chk("load_en_pulses", 144'(load_en), 144'(tbl[v].k));
      if (!tbl[v].gap) begin
        chk("latency", 144'(rise_cyc - t0), 144'(tbl[v].k + 8));
        chk("clear_then_en", 144'(first_en), 144'(last_clr + 1));
      end
    end

    // Hold the result beat under backpressure.
    m_axis_ready = 1'b0;
    send_tile(1, 48'h060504030201, 0, 0, 0, 0, tbl[1].exp, t0);
    n = 0;
    while (!m_axis_valid && n < 50) begin @(negedge axi_clk); n++; end
    chk("stall_valid_timeout", 144'(n >= 50), 0);
    outs_before = rd_idx;
    for (int c = 0; c < 20; c++) begin
      @(negedge axi_clk);
      chk("stall_data", m_axis_data, tbl[1].exp);
      chk("stall_valid", 144'(m_axis_valid), 144'(1));
      chk("stall_s_ready", 144'(s_axis_ready), 0);
    end
    @(posedge axi_clk); #1 m_axis_ready = 1'b1;
    @(negedge axi_clk);
    @(negedge axi_clk);
    chk("stall_release_valid", 144'(m_axis_valid), 0);
    chk("stall_one_beat", 144'(rd_idx - outs_before), 144'(1));

    // Reset during LOAD after one of three beats.
    @(posedge axi_clk); #1;
    cfg_k_len = 8'd3; s_axis_valid = 1'b1; s_axis_data = 48'h050505050505;
    n = 0;
    do begin @(negedge axi_clk); n++; end while (!(s_axis_valid && s_axis_ready) && n < 20);
    chk("mid_load_reach", 144'(n >= 20), 0);
    @(negedge axi_clk);
    axi_rst = 1'b1; #1;
    chk("mid_rst_s_ready", 144'(s_axis_ready), 0);
    chk("mid_rst_strobes", 144'({arr_clear, arr_en}), 0);
    chk("mid_rst_operands", 144'({arr_a, arr_b}), 0);
    chk("mid_rst_m", 144'({m_axis_valid, busy}), 0);
    chk("mid_rst_m_data", m_axis_data, 0);
    s_axis_valid = 1'b0;
    @(posedge axi_clk); #1 axi_rst = 1'b0;
    send_tile(1, 48'h090807020304, 0, 0, 0, 0, calc(1, 48'h090807020304, 0, 0, 0), t0);
    wait_done();
`ifdef SA_CTRL_PERF_EN
    chk("perf_tiles", 144'(perf_tiles), 144'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
